// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the IF stage.
//
// Selects the next fetch PC with the priority exception > branch/jump redirect >
// latched pending redirect > RAS return prediction > sequential increment.
// Redirects that arrive while the PC is frozen are latched and applied on the
// next advancing edge. A circular return-address stack predicts return targets.
//
// Parameters:
//   XLEN       PC width in bits
//   RESET_VEC  PC value loaded on reset
//   INC        sequential increment
//   RAS_DEPTH  RAS entries (power of two, >= 2)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   start_i        global run enable
//   pcwrite_i      hazard unit PC write enable
//   stall_i        pipeline stall
//   exc_valid_i    exception redirect request, target exc_pc_i
//   redir_valid_i  branch/jump redirect request, target redir_pc_i
//   ras_push_i     push ras_push_pc_i onto the RAS
//   ras_pop_i      predict next PC from the RAS top
//   pc_o           current fetch PC
//   pend_o         a redirect is latched and not yet applied
//   ras_count_o    number of valid RAS entries
//   ras_ovf_o      sticky: a push overwrote a valid entry
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     INC       = 4,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         pcwrite_i,
    input  logic                         stall_i,
    input  logic                         exc_valid_i,
    input  logic [XLEN-1:0]              exc_pc_i,
    input  logic                         redir_valid_i,
    input  logic [XLEN-1:0]              redir_pc_i,
    input  logic                         ras_push_i,
    input  logic [XLEN-1:0]              ras_push_pc_i,
    input  logic                         ras_pop_i,
    output logic [XLEN-1:0]              pc_o,
    output logic                         pend_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
    output logic                         ras_ovf_o
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        SrcNone,
        SrcBr,
        SrcExc
    } pend_src_e;

    logic                adv;
    logic [XLEN-1:0]     pc_q, pc_d;
    pend_src_e           src_q, src_d;
    logic [XLEN-1:0]     ppc_q, ppc_d;
    logic [PtrW-1:0]     tos_q, tos_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [XLEN-1:0]     ras_q [RAS_DEPTH];
    logic                ras_we;
    logic [PtrW-1:0]     ras_wa;
    logic                ras_has;

    assign adv     = start_i & pcwrite_i & ~stall_i;
    assign ras_has = (cnt_q != '0);

    always_comb begin
        pc_d   = pc_q;
        src_d  = src_q;
        ppc_d  = ppc_q;
        tos_d  = tos_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        ras_we = 1'b0;
        ras_wa = tos_q;

        if (adv) begin
            // The latch always clears on an advancing edge, used or not.
            src_d = SrcNone;
            if (exc_valid_i) begin
                pc_d = exc_pc_i;
            end else if (redir_valid_i) begin
                pc_d = redir_pc_i;
            end else if (src_q != SrcNone) begin
                pc_d = ppc_q;
            end else begin
                // Unsquashed edge: RAS operations apply here only.
                pc_d = pc_q + XLEN'(INC);
                if (ras_push_i && ras_pop_i && ras_has) begin
                    // Replace the top in place; tos and count unchanged.
                    pc_d   = ras_q[tos_q];
                    ras_we = 1'b1;
                    ras_wa = tos_q;
                end else if (ras_push_i) begin
                    tos_d  = tos_q + 1'b1;
                    ras_we = 1'b1;
                    ras_wa = tos_q + 1'b1;
                    if (cnt_q == CntW'(RAS_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (ras_pop_i && ras_has) begin
                    pc_d  = ras_q[tos_q];
                    tos_d = tos_q - 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end else begin
            // A pending exception is never displaced by a later branch redirect.
            if (exc_valid_i) begin
                src_d = SrcExc;
                ppc_d = exc_pc_i;
            end else if (redir_valid_i && (src_q != SrcExc)) begin
                src_d = SrcBr;
                ppc_d = redir_pc_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q  <= RESET_VEC;
            src_q <= SrcNone;
            ppc_q <= '0;
            tos_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            src_q <= src_d;
            ppc_q <= ppc_d;
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (ras_we) begin
                ras_q[ras_wa] <= ras_push_pc_i;
            end
        end
    end

    assign pc_o        = pc_q;
    assign pend_o      = (src_q != SrcNone);
    assign ras_count_o = cnt_q;
    assign ras_ovf_o   = ovf_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, pcwrite_i, stall_i;
    logic        exc_valid_i, redir_valid_i, ras_push_i, ras_pop_i;
    logic [31:0] exc_pc_i, redir_pc_i, ras_push_pc_i;
    logic [31:0] pc_o;
    logic        pend_o;
    logic [2:0]  ras_count_o;
    logic        ras_ovf_o;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic        pend;
        logic [2:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h100),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pcwrite_i     (pcwrite_i),
        .stall_i       (stall_i),
        .exc_valid_i   (exc_valid_i),
        .exc_pc_i      (exc_pc_i),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    (redir_pc_i),
        .ras_push_i    (ras_push_i),
        .ras_push_pc_i (ras_push_pc_i),
        .ras_pop_i     (ras_pop_i),
        .pc_o          (pc_o),
        .pend_o        (pend_o),
        .ras_count_o   (ras_count_o),
        .ras_ovf_o     (ras_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are registered, so compare on the falling edge.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "pc",    pc_o,                 e.pc);
            chk(e.nm, "pend",  {31'b0, pend_o},      {31'b0, e.pend});
            chk(e.nm, "count", {29'b0, ras_count_o}, {29'b0, e.cnt});
            chk(e.nm, "ovf",   {31'b0, ras_ovf_o},   {31'b0, e.ovf});
        end
    end

    task automatic defaults();
        start_i       = 1'b1;
        pcwrite_i     = 1'b1;
        stall_i       = 1'b0;
        exc_valid_i   = 1'b0;
        exc_pc_i      = '0;
        redir_valid_i = 1'b0;
        redir_pc_i    = '0;
        ras_push_i    = 1'b0;
        ras_push_pc_i = '0;
        ras_pop_i     = 1'b0;
    endtask

    // Inputs are set by the caller at a falling edge; expectation applies after the next edge.
    task automatic go(input string nm, input logic [31:0] pc, input logic pend,
                      input logic [2:0] cnt, input logic ovf);
        exp_t e;
        @(posedge clk_i);
        e.nm = nm; e.pc = pc; e.pend = pend; e.cnt = cnt; e.ovf = ovf;
        exp_q.push_back(e);
        @(negedge clk_i);
        defaults();
    endtask

    // Reset pulse that begins and ends between rising edges.
    task automatic async_rst(input string nm);
        exp_t e;
        defaults();
        stall_i = 1'b1;
        #2 rst_i = 1'b0;
        #1;
        e.nm = nm; e.pc = 32'h100; e.pend = 1'b0; e.cnt = 3'd0; e.ovf = 1'b0;
        exp_q.push_back(e);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        defaults();
    endtask

    initial begin
        defaults();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        start_i = 1'b0;
        go("rst_hold", 32'h100, 0, 0, 0);
        go("seq1", 32'h104, 0, 0, 0);
        go("seq2", 32'h108, 0, 0, 0);
        go("seq3", 32'h10C, 0, 0, 0);

        stall_i = 1; redir_valid_i = 1; redir_pc_i = 32'h200;
        go("br_latch", 32'h10C, 1, 0, 0);
        stall_i = 1;
        go("br_hold", 32'h10C, 1, 0, 0);
        go("br_apply", 32'h200, 0, 0, 0);

        stall_i = 1; exc_valid_i = 1; exc_pc_i = 32'h80;
        go("exc_latch", 32'h200, 1, 0, 0);
        stall_i = 1; redir_valid_i = 1; redir_pc_i = 32'h300;
        go("exc_keep", 32'h200, 1, 0, 0);
        go("exc_apply", 32'h80, 0, 0, 0);

        start_i = 0; redir_valid_i = 1; redir_pc_i = 32'h500;
        go("nostart_latch", 32'h80, 1, 0, 0);
        go("nostart_apply", 32'h500, 0, 0, 0);

        ras_push_i = 1; ras_push_pc_i = 32'hA0; go("push1", 32'h504, 0, 1, 0);
        ras_push_i = 1; ras_push_pc_i = 32'hA4; go("push2", 32'h508, 0, 2, 0);
        ras_push_i = 1; ras_push_pc_i = 32'hA8; go("push3", 32'h50C, 0, 3, 0);
        ras_push_i = 1; ras_push_pc_i = 32'hAC; go("push4", 32'h510, 0, 4, 0);
        ras_push_i = 1; ras_push_pc_i = 32'hB0; go("push_ovf", 32'h514, 0, 4, 1);
        ras_pop_i = 1; go("pop1", 32'hB0, 0, 3, 1);
        ras_pop_i = 1; go("pop2", 32'hAC, 0, 2, 1);
        ras_pop_i = 1; go("pop3", 32'hA8, 0, 1, 1);
        ras_pop_i = 1; go("pop4", 32'hA4, 0, 0, 1);
        ras_pop_i = 1; go("pop_empty", 32'hA8, 0, 0, 1);

        ras_push_i = 1; ras_push_pc_i = 32'h40; go("push40", 32'hAC, 0, 1, 1);
        ras_pop_i = 1; ras_push_i = 1; ras_push_pc_i = 32'h50;
        redir_valid_i = 1; redir_pc_i = 32'h600;
        go("squash", 32'h600, 0, 1, 1);
        ras_pop_i = 1; go("pop40", 32'h40, 0, 0, 1);
        ras_push_i = 1; ras_push_pc_i = 32'h60; go("push60", 32'h44, 0, 1, 1);
        ras_pop_i = 1; ras_push_i = 1; ras_push_pc_i = 32'h70;
        go("pushpop", 32'h60, 0, 1, 1);
        ras_pop_i = 1; go("pop70", 32'h70, 0, 0, 1);
        ras_pop_i = 1; ras_push_i = 1; ras_push_pc_i = 32'h90;
        go("pushpop_empty", 32'h74, 0, 1, 1);
        ras_pop_i = 1; go("pop90", 32'h90, 0, 0, 1);

        pcwrite_i = 0; redir_valid_i = 1; redir_pc_i = 32'h123;
        go("nopcw_latch", 32'h90, 1, 0, 1);
        exc_valid_i = 1; exc_pc_i = 32'h800; redir_valid_i = 1; redir_pc_i = 32'h900;
        go("exc_prio", 32'h800, 0, 0, 1);

        redir_valid_i = 1; redir_pc_i = 32'hFFFF_FFFC;
        go("to_top", 32'hFFFF_FFFC, 0, 0, 1);
        go("wrap", 32'h0, 0, 0, 1);
        ras_push_i = 1; ras_push_pc_i = 32'hC0; go("pushC0", 32'h4, 0, 1, 1);
        stall_i = 1; redir_valid_i = 1; redir_pc_i = 32'h700;
        go("pre_rst", 32'h4, 1, 1, 1);
        async_rst("async_rst");
        ras_pop_i = 1; go("post_rst", 32'h104, 0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_i);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
